// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the register-file write bundle used by the arbiter and
// the writeback stage.
package regfile_write_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } rf_write_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// Small in-order queue of long-latency results with per-entry valid bits,
// address-based squash and a one-hot pending-register mask.
module wb_pending_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq,
  input  logic [REG_IDX_W-1:0] enq_reg,
  input  logic [DATA_W-1:0]    enq_data,
  input  logic                 deq,
  input  logic                 squash,
  input  logic [REG_IDX_W-1:0] squash_reg,
  output logic                 empty,
  output logic                 full,
  output logic                 head_valid,
  output logic [REG_IDX_W-1:0] head_reg,
  output logic [DATA_W-1:0]    head_data,
  output logic [31:0]          pending_mask
);

  logic [REG_IDX_W-1:0] reg_q  [DEPTH];
  logic [REG_IDX_W-1:0] reg_d  [DEPTH];
  logic [DATA_W-1:0]    data_q [DEPTH];
  logic [DATA_W-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 enq_ok, deq_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign head_valid = valid_q[rd_ptr_q];
  assign head_reg   = reg_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign enq_ok     = enq && !full;
  assign deq_ok     = deq && !empty;

  // Squash first so an incoming entry to the squashed register lands invalid.
  always_comb begin
    reg_d    = reg_q;
    data_d   = data_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash && (reg_q[i] == squash_reg)) valid_d[i] = 1'b0;
    end
    if (deq_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (enq_ok) begin
      reg_d[wr_ptr_q]   = enq_reg;
      data_d[wr_ptr_q]  = enq_data;
      valid_d[wr_ptr_q] = !(squash && (enq_reg == squash_reg));
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= REG_ZERO;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= reg_d[i];
        data_q[i] <= data_d[i];
      end
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_mask[reg_q[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register-file write port: pipeline writeback has absolute
// priority, queued long-latency results fill idle slots.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_RegWrite,
  input  logic [REG_IDX_W-1:0] wb_Write_register,
  input  logic [DATA_W-1:0]    wb_Write_data,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [REG_IDX_W-1:0] lu_Write_register,
  input  logic [DATA_W-1:0]    lu_Write_data,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] Write_register,
  output logic [DATA_W-1:0]    Write_data,
  output logic [31:0]          pending_mask,
  output logic                 stall_req
);

  rf_write_t            out_q, out_d;
  logic                 run_q, run_d;
  logic                 pipe_issue, enq, deq;
  logic                 fifo_empty, fifo_full, head_valid;
  logic [REG_IDX_W-1:0] head_reg;
  logic [DATA_W-1:0]    head_data;

  assign pipe_issue = wb_RegWrite && (wb_Write_register != REG_ZERO);
  assign enq        = lu_valid && lu_ready && (lu_Write_register != REG_ZERO);
  assign deq        = !pipe_issue && !fifo_empty;
  // run_q keeps lu_ready low until the first edge after reset release.
  assign lu_ready   = run_q && !fifo_full;
  assign stall_req  = fifo_full;

  wb_pending_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .enq          (enq),
    .enq_reg      (lu_Write_register),
    .enq_data     (lu_Write_data),
    .deq          (deq),
    .squash       (pipe_issue),
    .squash_reg   (wb_Write_register),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .head_valid   (head_valid),
    .head_reg     (head_reg),
    .head_data    (head_data),
    .pending_mask (pending_mask)
  );

  // Invalid (squashed) heads still consume the drain slot but write nothing.
  always_comb begin
    run_d = 1'b1;
    out_d = '{en: 1'b0, addr: out_q.addr, data: out_q.data};
    if (pipe_issue) begin
      out_d = '{en: 1'b1, addr: wb_Write_register, data: wb_Write_data};
    end else if (!fifo_empty && head_valid) begin
      out_d = '{en: 1'b1, addr: head_reg, data: head_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      run_q <= 1'b0;
    end else begin
      out_q <= out_d;
      run_q <= run_d;
    end
  end

  assign RegWrite       = out_q.en;
  assign Write_register = out_q.addr;
  assign Write_data     = out_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: each step pushes the write expected one cycle later into a
// scoreboard queue, popped and compared when the registered outputs update.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_Write_register = '0;
  logic [31:0] wb_Write_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_Write_register = '0;
  logic [31:0] lu_Write_data = '0;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;
  logic        stall_req;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  rf_write_t exp_q[$];

  localparam rf_write_t IDLE = '0;

  regfile_write_arbiter #(.DEPTH(2), .PTR_W(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_RegWrite       (wb_RegWrite),
    .wb_Write_register (wb_Write_register),
    .wb_Write_data     (wb_Write_data),
    .lu_valid          (lu_valid),
    .lu_ready          (lu_ready),
    .lu_Write_register (lu_Write_register),
    .lu_Write_data     (lu_Write_data),
    .RegWrite          (RegWrite),
    .Write_register    (Write_register),
    .Write_data        (Write_data),
    .pending_mask      (pending_mask),
    .stall_req         (stall_req)
  );

  always #5 clk = ~clk;

  function automatic rf_write_t wr(input logic [4:0] a, input logic [31:0] d);
    return '{en: 1'b1, addr: a, data: d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and record the write expected next cycle.
  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdat,
                       input logic lv, input logic [4:0] lreg, input logic [31:0] ldat,
                       input rf_write_t exp);
    wb_RegWrite       = we;
    wb_Write_register = wreg;
    wb_Write_data     = wdat;
    lu_valid          = lv;
    lu_Write_register = lreg;
    lu_Write_data     = ldat;
    exp_q.push_back(exp);
  endtask

  task automatic tick();
    rf_write_t e;
    @(posedge clk);
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE;
    check("RegWrite", {31'd0, RegWrite}, {31'd0, e.en});
    if (e.en) begin
      check("Write_register", {27'd0, Write_register}, {27'd0, e.addr});
      check("Write_data", Write_data, e.data);
    end
    if (RegWrite) check("no_reg0_write", {31'd0, Write_register != 5'd0}, 32'd1);
  endtask

  initial begin
    // Reset held with an offer present.
    lu_valid = 1'b1;
    lu_Write_register = 5'd7;
    lu_Write_data = 32'h77;
    repeat (2) @(posedge clk);
    #1;
    check("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    check("rst_pending", pending_mask, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_lu_ready_pre_edge", {31'd0, lu_ready}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();
    check("rel_lu_ready", {31'd0, lu_ready}, 32'd1);

    // Priority: queued $8 waits behind two pipeline writes.
    drive(0, 0, 0, 1, 5'd8, 32'hAAAA0001, IDLE);
    tick();
    check("prio_pend8_c1", {31'd0, pending_mask[8]}, 32'd1);
    drive(1, 5'd9, 32'h11, 0, 0, 0, wr(5'd9, 32'h11));
    tick();
    check("prio_pend8_c2", {31'd0, pending_mask[8]}, 32'd1);
    drive(1, 5'd10, 32'h22, 0, 0, 0, wr(5'd10, 32'h22));
    tick();
    check("prio_pend8_c3", {31'd0, pending_mask[8]}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, wr(5'd8, 32'hAAAA0001));
    tick();
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();
    check("prio_pend8_c5", pending_mask, 32'd0);

    // Full / back-pressure with continuous pipeline writes.
    drive(1, 5'd1, 32'h101, 1, 5'd11, 32'hB1, wr(5'd1, 32'h101));
    tick();
    check("full_ready_1", {31'd0, lu_ready}, 32'd1);
    check("full_stall_1", {31'd0, stall_req}, 32'd0);
    drive(1, 5'd2, 32'h102, 1, 5'd12, 32'hB2, wr(5'd2, 32'h102));
    tick();
    check("full_ready_2", {31'd0, lu_ready}, 32'd0);
    check("full_stall_2", {31'd0, stall_req}, 32'd1);
    check("full_pending", pending_mask, 32'h0000_1800);
    drive(1, 5'd3, 32'h103, 1, 5'd13, 32'hB3, wr(5'd3, 32'h103));
    tick();
    check("full_ready_3", {31'd0, lu_ready}, 32'd0);
    check("full_stall_3", {31'd0, stall_req}, 32'd1);
    check("full_pending_3", pending_mask, 32'h0000_1800);
    drive(0, 0, 0, 0, 0, 0, wr(5'd11, 32'hB1));
    tick();
    check("drain_ready", {31'd0, lu_ready}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, wr(5'd12, 32'hB2));
    tick();
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();
    check("drain_pending", pending_mask, 32'd0);

    // Squash of a queued entry by a younger pipeline write.
    drive(0, 0, 0, 1, 5'd5, 32'hDEAD, IDLE);
    tick();
    check("sq_pend5_set", {31'd0, pending_mask[5]}, 32'd1);
    drive(1, 5'd5, 32'hBEEF, 0, 0, 0, wr(5'd5, 32'hBEEF));
    tick();
    check("sq_pend5_clr", {31'd0, pending_mask[5]}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();
    drive(1, 5'd1, 32'h201, 1, 5'd20, 32'h2020, wr(5'd1, 32'h201));
    tick();
    check("sq_dead_gone_stall", {31'd0, stall_req}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, wr(5'd20, 32'h2020));
    tick();
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();

    // Same-cycle transfer to the register being written lands invalid.
    drive(1, 5'd6, 32'h600, 1, 5'd6, 32'h6666, wr(5'd6, 32'h600));
    tick();
    check("sq_inflight_pend", pending_mask, 32'd0);
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();

    // $0 handling.
    drive(0, 0, 0, 1, 5'd0, 32'hFF, IDLE);
    #1;
    check("z_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    check("z_pending", pending_mask, 32'd0);
    drive(1, 5'd1, 32'h301, 1, 5'd3, 32'h33, wr(5'd1, 32'h301));
    tick();
    check("z_count_one", {31'd0, stall_req}, 32'd0);
    check("z_pend3", pending_mask, 32'h0000_0008);
    drive(1, 5'd0, 32'h999, 0, 0, 0, wr(5'd3, 32'h33));
    tick();
    drive(0, 0, 0, 0, 0, 0, IDLE);
    tick();
    check("z_pending_end", pending_mask, 32'd0);

    // Reset mid-operation with a full queue.
    drive(1, 5'd1, 32'h401, 1, 5'd14, 32'hE1, wr(5'd1, 32'h401));
    tick();
    drive(1, 5'd2, 32'h402, 1, 5'd15, 32'hE2, wr(5'd2, 32'h402));
    tick();
    check("mr_full", {31'd0, stall_req}, 32'd1);
    wb_RegWrite = 1'b0;
    lu_valid    = 1'b0;
    reset       = 1'b0;
    #1;
    check("mr_pending", pending_mask, 32'd0);
    check("mr_stall", {31'd0, stall_req}, 32'd0);
    check("mr_RegWrite", {31'd0, RegWrite}, 32'd0);
    check("mr_lu_ready", {31'd0, lu_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, IDLE);
      tick();
    end
    check("mr_ready_after", {31'd0, lu_ready}, 32'd1);
    check("mr_pending_after", pending_mask, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
